// File: rtl/range_pkg.sv
// Shared types and sizes for the echo range scanner: scan state encoding,
// channel/width sizing and small channel-select helpers.
package range_pkg;

    localparam int NUM_CH  = 3;
    localparam int CH_W    = 2;
    localparam int WIDTH_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        GUARD     = 3'd4
    } scan_state_e;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] oh;
        case (ch)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Round-robin successor: 0 -> 1 -> 2 -> 0.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every PRESCALE clocks while
// enabled; held at zero when disabled so the tick phase restarts cleanly.
module tick_prescaler #(
    parameter int PRESCALE = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/echo_range_scanner.sv
// Round-robin ultrasonic ranging front end: triggers three sensors in turn,
// times each echo in ticks and debounces the near/far result per channel.
module echo_range_scanner
    import range_pkg::*;
#(
    parameter int PRESCALE      = 10,
    parameter int TRIG_TICKS    = 10,
    parameter int TIMEOUT_TICKS = 30000,
    parameter int NEAR_TICKS    = 5800,
    parameter int GUARD_TICKS   = 10000,
    parameter int CONFIRM       = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NUM_CH-1:0]  echo,
    output logic [NUM_CH-1:0]  trig,
    output logic [NUM_CH-1:0]  near,
    output logic               meas_valid,
    output logic [CH_W-1:0]    meas_ch,
    output logic [WIDTH_W-1:0] meas_width,
    output logic               meas_timeout
);

    localparam logic [WIDTH_W-1:0] ONE          = WIDTH_W'(1);
    localparam logic [WIDTH_W-1:0] TRIG_LAST    = WIDTH_W'(TRIG_TICKS - 1);
    localparam logic [WIDTH_W-1:0] TIMEOUT_LAST = WIDTH_W'(TIMEOUT_TICKS - 1);
    localparam logic [WIDTH_W-1:0] TIMEOUT_W    = WIDTH_W'(TIMEOUT_TICKS);
    localparam logic [WIDTH_W-1:0] GUARD_LAST   = WIDTH_W'(GUARD_TICKS - 1);
    localparam logic [WIDTH_W-1:0] NEAR_LIM     = WIDTH_W'(NEAR_TICKS);
    localparam logic [1:0]         CONF_LAST    = 2'(CONFIRM - 1);

    logic tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ena),
        .tick  (tick)
    );

    logic [NUM_CH-1:0] echo_meta;
    logic [NUM_CH-1:0] echo_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= '0;
            echo_sync <= '0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;
        end
    end

    scan_state_e        state, state_d;
    logic [CH_W-1:0]    sel, sel_d;
    logic [WIDTH_W-1:0] cnt, cnt_d;
    logic [NUM_CH-1:0]  trig_d;
    logic               res_valid;
    logic [WIDTH_W-1:0] res_width;
    logic               res_timeout;
    logic               echo_act;
    logic               meas_near;

    assign echo_act = echo_sync[sel];

    // The width counter also counts a tick coinciding with the detected rise,
    // so an echo high for N*PRESCALE clocks always measures N ticks.
    always_comb begin
        state_d     = state;
        sel_d       = sel;
        cnt_d       = cnt;
        trig_d      = trig;
        res_valid   = 1'b0;
        res_width   = cnt;
        res_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                    trig_d  = ch_onehot(sel);
                end
            end
            TRIG: begin
                if (tick) begin
                    if (cnt == TRIG_LAST) begin
                        trig_d  = '0;
                        state_d = WAIT_RISE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
            end
            WAIT_RISE: begin
                if (echo_act) begin
                    state_d = MEASURE;
                    cnt_d   = tick ? ONE : '0;
                end else if (tick) begin
                    if (cnt == TIMEOUT_LAST) begin
                        res_valid   = 1'b1;
                        res_width   = TIMEOUT_W;
                        res_timeout = 1'b1;
                        state_d     = GUARD;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
            end
            MEASURE: begin
                if (!echo_act) begin
                    res_valid = 1'b1;
                    res_width = cnt;
                    state_d   = GUARD;
                    cnt_d     = '0;
                end else if (tick) begin
                    if (cnt == TIMEOUT_LAST) begin
                        res_valid   = 1'b1;
                        res_width   = TIMEOUT_W;
                        res_timeout = 1'b1;
                        state_d     = GUARD;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
            end
            GUARD: begin
                if (tick) begin
                    if (cnt == GUARD_LAST) begin
                        sel_d   = next_ch(sel);
                        trig_d  = ch_onehot(next_ch(sel));
                        state_d = TRIG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!ena) begin
            state_d   = IDLE;
            sel_d     = '0;
            cnt_d     = '0;
            trig_d    = '0;
            res_valid = 1'b0;
        end
    end

    // meas_valid is a one-cycle strobe with no back-pressure; meas_ch,
    // meas_width and meas_timeout are valid with it and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel          <= '0;
            cnt          <= '0;
            trig         <= '0;
            meas_valid   <= 1'b0;
            meas_ch      <= '0;
            meas_width   <= '0;
            meas_timeout <= 1'b0;
            meas_near    <= 1'b0;
        end else begin
            state      <= state_d;
            sel        <= sel_d;
            cnt        <= cnt_d;
            trig       <= trig_d;
            meas_valid <= res_valid;
            if (res_valid) begin
                meas_ch      <= sel;
                meas_width   <= res_width;
                meas_timeout <= res_timeout;
                meas_near    <= !res_timeout && (res_width < NEAR_LIM);
            end
        end
    end

    // Per-channel run of results disagreeing with the current near bit.
    logic [1:0] conf [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            near <= '0;
            for (int i = 0; i < NUM_CH; i++) conf[i] <= 2'd0;
        end else if (!ena) begin
            near <= '0;
            for (int i = 0; i < NUM_CH; i++) conf[i] <= 2'd0;
        end else if (meas_valid) begin
            if (meas_near != near[meas_ch]) begin
                if (conf[meas_ch] == CONF_LAST) begin
                    near[meas_ch] <= meas_near;
                    conf[meas_ch] <= 2'd0;
                end else begin
                    conf[meas_ch] <= conf[meas_ch] + 2'd1;
                end
            end else begin
                conf[meas_ch] <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_echo_range_scanner.sv
// Randomized bench for echo_range_scanner: scan drivers push expected results
// from a behavioural model; a monitor pops them on every meas_valid.
module tb_echo_range_scanner;
    import range_pkg::*;

    localparam int PRESCALE      = 2;
    localparam int TRIG_TICKS    = 2;
    localparam int TIMEOUT_TICKS = 50;
    localparam int NEAR_TICKS    = 20;
    localparam int GUARD_TICKS   = 5;
    localparam int CONFIRM       = 2;
    localparam int EW            = 22;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [2:0]  echo = 3'b000;
    logic [2:0]  trig;
    logic [2:0]  near;
    logic        meas_valid;
    logic [1:0]  meas_ch;
    logic [15:0] meas_width;
    logic        meas_timeout;

    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q[$];
    logic [2:0] m_near;
    int m_dis[3];
    int cur_ch;

    echo_range_scanner #(
        .PRESCALE      (PRESCALE),
        .TRIG_TICKS    (TRIG_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .NEAR_TICKS    (NEAR_TICKS),
        .GUARD_TICKS   (GUARD_TICKS),
        .CONFIRM       (CONFIRM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .echo         (echo),
        .trig         (trig),
        .near         (near),
        .meas_valid   (meas_valid),
        .meas_ch      (meas_ch),
        .meas_width   (meas_width),
        .meas_timeout (meas_timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_near = 3'b000;
        for (int i = 0; i < 3; i++) m_dis[i] = 0;
    endtask

    // Reference: an echo of w ticks is near iff w < NEAR_TICKS; no echo or
    // w >= TIMEOUT_TICKS is a timeout of width TIMEOUT_TICKS. A near bit flips
    // after CONFIRM consecutive results that disagree with it.
    task automatic push_expect(input int ch, input int w, input bit no_echo);
        int  ew;
        bit  eto;
        bit  raw;
        if (no_echo || w >= TIMEOUT_TICKS) begin
            ew  = TIMEOUT_TICKS;
            eto = 1'b1;
        end else begin
            ew  = w;
            eto = 1'b0;
        end
        raw = !eto && (ew < NEAR_TICKS);
        if (raw != m_near[ch]) begin
            m_dis[ch]++;
            if (m_dis[ch] >= CONFIRM) begin
                m_near[ch] = raw;
                m_dis[ch]  = 0;
            end
        end else begin
            m_dis[ch] = 0;
        end
        exp_q.push_back({2'(ch), 16'(ew), eto, m_near});
    endtask

    task automatic wait_trig(output int n);
        n = 0;
        while (trig == 3'b000 && n < 600) begin
            @(negedge clk);
            n++;
        end
    endtask

    // kind: 0 = no echo, 1 = pulse of w ticks, 2 = echo stuck high
    task automatic do_scan(input int kind, input int w, input bit noise);
        int n;
        int d;
        logic [2:0] oh;
        oh = 3'b001 << cur_ch;
        wait_trig(n);
        check("trig_onehot", 32'(trig), 32'(oh));
        n = 0;
        while (trig == oh && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("trig_len", n, TRIG_TICKS * PRESCALE);
        check("trig_off", 32'(trig), 0);
        case (kind)
            0: push_expect(cur_ch, 0, 1'b1);
            1: begin
                push_expect(cur_ch, w, 1'b0);
                d = $urandom_range(0, 20);
                repeat (d) @(negedge clk);
                for (int i = 0; i < 2 * w; i++) begin
                    echo = noise ? ((3'($urandom) & ~oh) | oh) : oh;
                    @(negedge clk);
                end
                echo = 3'b000;
            end
            default: begin
                push_expect(cur_ch, 0, 1'b1);
                echo = oh;
                n = 0;
                while (!meas_valid && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                echo = 3'b000;
            end
        endcase
        cur_ch = (cur_ch + 1) % 3;
    endtask

    // scoreboard monitor
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (meas_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_meas: got ch=%0d width=%0d expected no result",
                             meas_ch, meas_width);
                end else begin
                    e = exp_q.pop_front();
                    check("meas_ch", 32'(meas_ch), 32'(e[21:20]));
                    check("meas_width", 32'(meas_width), 32'(e[19:4]));
                    check("meas_timeout", 32'(meas_timeout), 32'(e[3]));
                    @(negedge clk);
                    check("meas_valid_pulse", 32'(meas_valid), 0);
                    check("near", 32'(near), 32'(e[2:0]));
                end
            end
        end
    end

    initial begin
        int n;
        int k;
        model_reset();
        cur_ch = 0;
        echo = 3'b111;
        repeat (3) begin
            @(negedge clk);
            check("rst_trig", 32'(trig), 0);
            check("rst_near", 32'(near), 0);
            check("rst_valid", 32'(meas_valid), 0);
        end
        check("rst_ch", 32'(meas_ch), 0);
        check("rst_width", 32'(meas_width), 0);
        check("rst_timeout", 32'(meas_timeout), 0);
        echo = 3'b000;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("disabled_trig", 32'(trig), 0);
        ena = 1'b1;

        // directed boundaries
        do_scan(1, 10, 1'b0);
        do_scan(0, 0, 1'b0);
        do_scan(2, 0, 1'b0);
        do_scan(1, 10, 1'b1);
        do_scan(1, 20, 1'b0);
        do_scan(1, 19, 1'b0);
        do_scan(1, 20, 1'b1);
        do_scan(1, 21, 1'b0);
        do_scan(1, 19, 1'b0);

        // abort a channel-0 measurement with ena
        wait_trig(n);
        check("abort_trig", 32'(trig), 1);
        n = 0;
        while (trig != 3'b000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        echo = 3'b001;
        repeat (10) @(negedge clk);
        check("pre_abort_near", 32'(near), 32'(m_near));
        ena = 1'b0;
        @(negedge clk);
        check("abort_trig_clear", 32'(trig), 0);
        check("abort_near_clear", 32'(near), 0);
        echo = 3'b000;
        repeat (20) @(negedge clk);
        model_reset();
        cur_ch = 0;
        ena = 1'b1;

        // randomized scans
        for (int s = 0; s < 30; s++) begin
            k = $urandom_range(0, 9);
            if (k == 0) do_scan(0, 0, 1'b0);
            else if (k == 1) do_scan(2, 0, 1'b0);
            else if (k < 6) do_scan(1, $urandom_range(15, 25), 1'($urandom_range(0, 1)));
            else do_scan(1, $urandom_range(1, 52), 1'($urandom_range(0, 1)));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
